// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the three buses around the data-memory arbiter: the pipeline
//   (EX/MEM) request bus, the auxiliary requester bus and the datamemory port.
//   Modports:
//     slave  - the arbiter: takes pipeline/aux requests and m_rdata, and drives
//              p_rdata/p_stall, the aux response and the m_* memory controls
//     master - the environment around the arbiter (pipeline, aux master, memory)
//   Parameters DATA_W / DM_ADDRESS must match those of the arbiter instance.
interface dmem_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
);
  logic                  p_rd;
  logic                  p_wr;
  logic [DM_ADDRESS-1:0] p_addr;
  logic [DATA_W-1:0]     p_wdata;
  logic [2:0]            p_func3;
  logic [DATA_W-1:0]     p_rdata;
  logic                  p_stall;

  logic                  a_req;
  logic                  a_we;
  logic [DM_ADDRESS-1:0] a_addr;
  logic [DATA_W-1:0]     a_wdata;
  logic [2:0]            a_func3;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_W-1:0]     a_rdata;

  logic                  m_rd;
  logic                  m_wr;
  logic [DM_ADDRESS-1:0] m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [2:0]            m_func3;
  logic [DATA_W-1:0]     m_rdata;

  modport slave (
    input  p_rd, p_wr, p_addr, p_wdata, p_func3,
    output p_rdata, p_stall,
    input  a_req, a_we, a_addr, a_wdata, a_func3,
    output a_gnt, a_rvalid, a_rdata,
    output m_rd, m_wr, m_addr, m_wdata, m_func3,
    input  m_rdata
  );

  modport master (
    output p_rd, p_wr, p_addr, p_wdata, p_func3,
    input  p_rdata, p_stall,
    output a_req, a_we, a_addr, a_wdata, a_func3,
    input  a_gnt, a_rvalid, a_rdata,
    input  m_rd, m_wr, m_addr, m_wdata, m_func3,
    output m_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single MEM-stage data-memory port between the pipeline (EX/MEM,
//   always preferred) and an auxiliary master (debug/loader/DMA) that uses
//   free cycles. If the aux master loses STARVE_LIM consecutive cycles, the
//   next cycle is a forced aux slot and the pipeline is stalled for that one
//   cycle only.
//   Ports:
//     clk            - clock, all state on rising edge
//     reset          - asynchronous, active-low reset
//     bus            - dmem_arbiter_if.slave (pipeline, aux and datamemory buses)
//     perf_stall_cnt - cycles with p_stall = 1 (16-bit saturating)
//     perf_aux_cnt   - aux grants (16-bit saturating)
//   Optional feature macro: DMEM_ARB_PERF_EN enables the performance counters;
//   when undefined both counter outputs are tied to zero and no flops exist.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                reset,
  dmem_arbiter_if.slave       bus,
  output logic [15:0]         perf_stall_cnt,
  output logic [15:0]         perf_aux_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM_M1   = CNT_W'(STARVE_LIM - 1);
  localparam logic [CNT_W-1:0] LIM_FULL = CNT_W'(STARVE_LIM);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      starve_cnt;
  logic [CNT_W-1:0]      starve_nxt;
  logic                  p_act;
  logic                  aux_gnt;
  logic                  aux_rd_gnt;
  logic                  stall;
  logic                  m_rd_c;
  logic                  m_wr_c;
  logic [DM_ADDRESS-1:0] m_addr_c;
  logic [DATA_W-1:0]     m_wdata_c;
  logic [2:0]            m_func3_c;
  logic                  rvalid_q;
  logic [DATA_W-1:0]     rdata_q;

  assign p_act      = bus.p_rd | bus.p_wr;
  assign aux_rd_gnt = aux_gnt & ~bus.a_we;

  // State register and starvation counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Next-state logic. The counter only survives a cycle in which aux is
  // requesting and losing to the pipeline; any grant or withdrawal clears it.
  // Reaching STARVE_LIM lost cycles schedules the forced slot for the next
  // cycle, which also covers STARVE_LIM = 1 straight from IDLE.
  always_comb begin
    state_nxt  = IDLE;
    starve_nxt = '0;
    case (state)
      IDLE, WAIT: begin
        if (bus.a_req && p_act) begin
          starve_nxt = (starve_cnt == LIM_FULL) ? starve_cnt : starve_cnt + 1'b1;
          state_nxt  = (starve_cnt == LIM_M1) ? FORCE : WAIT;
        end
      end
      default: begin
        state_nxt  = IDLE;
        starve_nxt = '0;
      end
    endcase
  end

  // Output logic: grant, stall and the memory-port mux. The pipeline path is
  // purely combinational so it sees no added latency.
  always_comb begin
    aux_gnt   = (state == FORCE) ? bus.a_req : (bus.a_req & ~p_act);
    stall     = (state == FORCE) & bus.a_req & p_act;
    m_rd_c    = bus.p_rd;
    m_wr_c    = bus.p_wr;
    m_addr_c  = bus.p_addr;
    m_wdata_c = bus.p_wdata;
    m_func3_c = bus.p_func3;
    if (aux_gnt) begin
      m_rd_c    = ~bus.a_we;
      m_wr_c    = bus.a_we;
      m_addr_c  = bus.a_addr;
      m_wdata_c = bus.a_wdata;
      m_func3_c = bus.a_func3;
    end
  end

  // Aux read response: capture the combinational memory data on the grant
  // cycle and pulse a_rvalid in the following cycle. Writes get no response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= aux_rd_gnt;
      if (aux_rd_gnt) begin
        rdata_q <= bus.m_rdata;
      end
    end
  end

  assign bus.a_gnt    = aux_gnt;
  assign bus.p_stall  = stall;
  assign bus.p_rdata  = bus.m_rdata;
  assign bus.a_rvalid = rvalid_q;
  assign bus.a_rdata  = rdata_q;
  assign bus.m_rd     = m_rd_c;
  assign bus.m_wr     = m_wr_c;
  assign bus.m_addr   = m_addr_c;
  assign bus.m_wdata  = m_wdata_c;
  assign bus.m_func3  = m_func3_c;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] aux_cnt_q;

  // Saturating performance counters: stalled cycles and aux grants.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      aux_cnt_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (aux_gnt && (aux_cnt_q != 16'hFFFF)) begin
        aux_cnt_q <= aux_cnt_q + 16'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_aux_cnt   = aux_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_aux_cnt   = '0;
`endif

endmodule
